// File: rtl/router_xy_buffered.sv
// router_xy_buffered: 5-port XY mesh router with per-input packet FIFOs and round-robin registered outputs.
module router_xy_buffered #(
  parameter int ROUTER_ROW   = 0,
  parameter int ROUTER_COL   = 0,
  parameter int GRID_WIDTH   = 4,
  parameter int PACKET_WIDTH = 32,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                         i_clk,
  input  logic                         i_arst_n,
  input  logic [4:0][PACKET_WIDTH-1:0] i_data,
  input  logic [4:0]                   i_valid,
  output logic [4:0]                   o_ready,
  output logic [4:0][PACKET_WIDTH-1:0] o_data,
  output logic [4:0]                   o_valid,
  input  logic [4:0]                   i_ready,
  output logic                         o_dropped
);
  localparam int CW = $clog2(GRID_WIDTH) > 1 ? $clog2(GRID_WIDTH) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW:0] GW  = (CW+1)'(GRID_WIDTH);
  localparam logic [CW:0] ROW = (CW+1)'(ROUTER_ROW);
  localparam logic [CW:0] COL = (CW+1)'(ROUTER_COL);
  logic [PACKET_WIDTH-1:0] mem [5][FIFO_DEPTH];
  logic [4:0][AW:0] wp, rp;
  logic [4:0] empty, full, drop, push, pop, gv, ok;
  logic [4:0][2:0] dir, gi, ptr;
  logic [4:0][CW:0] dr, dc;
  logic [4:0][PACKET_WIDTH-1:0] head;
  assign o_ready = ~full;
  assign push = i_valid & ~full;
  assign ok = ~o_valid | i_ready;
  assign o_dropped = |drop;
  always_comb begin
    for (int p = 0; p < 5; p++) begin
      head[p] = mem[p][rp[p][AW-1:0]];
      dc[p] = {1'b0, head[p][CW-1:0]};
      dr[p] = {1'b0, head[p][2*CW-1:CW]};
      empty[p] = wp[p] == rp[p];
      full[p] = (wp[p] ^ rp[p]) == {1'b1, {AW{1'b0}}};
      drop[p] = !empty[p] && (dr[p] >= GW || dc[p] >= GW);
      dir[p] = dc[p] == COL && dr[p] == ROW ? 3'd0 :
               dc[p] > COL ? 3'd3 : dc[p] < COL ? 3'd4 : dr[p] > ROW ? 3'd2 : 3'd1;
    end
  end
  // round-robin search per output, starting at ptr[q]; an out-of-grid head never requests
  always_comb begin
    logic [3:0] s;
    logic [2:0] i;
    gv = '0;
    gi = '0;
    pop = drop;
    s = '0;
    i = '0;
    for (int q = 0; q < 5; q++) begin
      for (int k = 0; k < 5; k++) begin
        s = {1'b0, ptr[q]} + 4'(k);
        i = s >= 4'd5 ? 3'(s - 4'd5) : s[2:0];
        if (!gv[q] && !empty[i] && !drop[i] && dir[i] == 3'(q)) begin
          gv[q] = 1'b1;
          gi[q] = i;
        end
      end
      if (gv[q] && ok[q]) pop[gi[q]] = 1'b1;
    end
  end
  always_ff @(posedge i_clk)
    for (int p = 0; p < 5; p++)
      if (push[p]) mem[p][wp[p][AW-1:0]] <= i_data[p];
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      wp <= '0;
      rp <= '0;
      ptr <= '0;
      o_valid <= '0;
      o_data <= '0;
    end else begin
      for (int p = 0; p < 5; p++) begin
        wp[p] <= wp[p] + (AW+1)'(push[p]);
        rp[p] <= rp[p] + (AW+1)'(pop[p]);
      end
      for (int q = 0; q < 5; q++)
        if (ok[q]) begin
          o_valid[q] <= gv[q];
          if (gv[q]) begin
            o_data[q] <= head[gi[q]];
            ptr[q] <= gi[q] == 3'd4 ? 3'd0 : gi[q] + 3'd1;
          end
        end
    end
  end
endmodule

// File: tb/tb_router_xy_buffered.sv
// tb_router_xy_buffered: directed and randomized checks of router_xy_buffered against a queue-based scoreboard.
module tb_router_xy_buffered;
  logic clk, rst_n;
  logic [4:0][31:0] i_data, o_data, b_data, b_odata;
  logic [4:0] i_valid, o_ready, o_valid, i_ready, b_valid, b_ordy, b_ovalid, b_irdy;
  logic o_dropped, b_drop;
  int total = 0, bad = 0, seq = 1;
  logic [31:0] sb [25][$];
  logic [4:0] hold = '0;
  logic [4:0][31:0] hold_d;
  logic [4:0] en = '0;
  int mode = 0;
  bit rnd_valid = 0, rnd_rdy = 0;

  router_xy_buffered #(.ROUTER_ROW(1), .ROUTER_COL(1), .GRID_WIDTH(4)) dut (
    .i_clk(clk), .i_arst_n(rst_n), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_dropped(o_dropped));
  router_xy_buffered #(.ROUTER_ROW(0), .ROUTER_COL(0), .GRID_WIDTH(3)) dut_b (
    .i_clk(clk), .i_arst_n(rst_n), .i_data(b_data), .i_valid(b_valid), .o_ready(b_ordy),
    .o_data(b_odata), .o_valid(b_ovalid), .i_ready(b_irdy), .o_dropped(b_drop));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // XY rule for the router at (1,1): column first, then row
  function automatic int route(input logic [31:0] pk);
    int r, c;
    r = int'(pk[3:2]);
    c = int'(pk[1:0]);
    if (r == 1 && c == 1) return 0;
    if (c > 1) return 3;
    if (c < 1) return 4;
    return r > 1 ? 2 : 1;
  endfunction

  function automatic logic [31:0] mkp(input int src, input int r, input int c);
    seq++;
    return {16'(seq), 5'd0, 3'(src), 4'd0, 2'(r), 2'(c)};
  endfunction

  function automatic logic [31:0] gen(input int p);
    if (mode == 1) return mkp(p, $urandom_range(0, 3), $urandom_range(2, 3));
    if (mode == 2) return p == 1 ? mkp(p, $urandom_range(2, 3), 1) : mkp(p, $urandom_range(0, 3), $urandom_range(2, 3));
    return mkp(p, $urandom_range(0, 3), $urandom_range(0, 3));
  endfunction

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < 25; i++) n += sb[i].size();
    return n;
  endfunction

  function automatic int nxt(input int s);
    return s == 0 ? 1 : s == 1 ? 2 : s == 2 ? 4 : 0;
  endfunction

  // scoreboard: packets are queued per (input, output) at acceptance and must leave in that order
  always @(negedge clk) begin
    int src, idx;
    if (!rst_n) begin
      for (int i = 0; i < 25; i++) sb[i].delete();
      hold = '0;
    end else begin
      for (int p = 0; p < 5; p++)
        if (i_valid[p] && o_ready[p]) sb[p*5 + route(i_data[p])].push_back(i_data[p]);
      for (int q = 0; q < 5; q++) begin
        if (hold[q]) chk("hold", {o_valid[q], o_data[q]}, {1'b1, hold_d[q]});
        if (o_valid[q] && i_ready[q]) begin
          src = int'(o_data[q][10:8]);
          chk("route", route(o_data[q]), q);
          idx = src*5 + q;
          if (src > 4) chk("src", src, 0);
          else if (sb[idx].size() == 0) chk("stale", sb[idx].size(), 1);
          else chk("order", o_data[q], sb[idx].pop_front());
        end
        hold[q] = o_valid[q] && !i_ready[q];
        hold_d[q] = o_data[q];
      end
      chk("nodrop", o_dropped, 0);
    end
  end

  task automatic step();
    logic [4:0] acc;
    acc = i_valid & o_ready;
    @(posedge clk); #1;
    for (int p = 0; p < 5; p++)
      if (!en[p]) i_valid[p] = 0;
      else if (acc[p] || !i_valid[p]) begin
        i_valid[p] = rnd_valid ? $urandom_range(0, 2) != 0 : 1'b1;
        i_data[p] = gen(p);
      end
    if (rnd_rdy) for (int q = 0; q < 5; q++) i_ready[q] = $urandom_range(0, 3) != 0;
  endtask

  task automatic route_one(input int r, input int c, input int q);
    logic [31:0] pk;
    pk = mkp(0, r, c);
    @(posedge clk); #1;
    i_valid[0] = 1; i_data[0] = pk;
    @(posedge clk); #1;
    i_valid[0] = 0;
    @(negedge clk); chk("lat1", o_valid, 0);
    @(negedge clk); chk("lat2_v", o_valid, 5'b1 << q); chk("lat2_d", o_data[q], pk);
  endtask

  task automatic drop_one(input int r, input int c);
    int cnt = 0;
    @(posedge clk); #1;
    b_valid[0] = 1; b_data[0] = {16'(seq), 12'd0, 2'(r), 2'(c)};
    @(posedge clk); #1;
    b_valid[0] = 0;
    repeat (6) begin
      @(negedge clk);
      cnt += int'(b_drop);
      chk("drop_nov", b_ovalid, 0);
    end
    chk("drop_cnt", cnt, 1);
    chk("drop_rdy", b_ordy, 5'h1f);
  endtask

  task automatic mid_reset();
    @(posedge clk); #3;
    rst_n = 0; en = '0; i_valid = '0;
    #1 chk("rst_ov", o_valid, 0);
    chk("rst_od", |o_data, 0);
    @(negedge clk); chk("rst_rdy", o_ready, 5'h1f);
    @(posedge clk); #1 rst_n = 1;
  endtask

  initial begin
    logic [31:0] pk [5];
    int prev, s;
    rst_n = 0; i_valid = '0; i_data = '0; i_ready = '1; b_valid = '0; b_data = '0; b_irdy = '1;
    #2;
    chk("reset_ov", o_valid, 0);
    chk("reset_od", |o_data, 0);
    chk("reset_rdy", o_ready, 5'h1f);
    chk("reset_drop", o_dropped, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk); chk("rel_rdy", o_ready, 5'h1f);

    route_one(1, 3, 3);
    route_one(1, 0, 4);
    route_one(3, 1, 2);
    route_one(0, 1, 1);
    route_one(1, 1, 0);

    i_ready[3] = 0;
    for (int k = 0; k < 5; k++) pk[k] = mkp(0, k % 4, 2 + k % 2);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      i_valid[0] = 1; i_data[0] = pk[k];
      @(negedge clk); chk("bp_rdy", o_ready[0], 1);
    end
    @(posedge clk); #1 i_valid[0] = 0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_full", o_ready[0], 0);
      chk("bp_v", o_valid[3], 1);
      chk("bp_d", o_data[3], pk[0]);
    end
    @(posedge clk); #1 i_ready[3] = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_out_v", o_valid[3], 1);
      chk("bp_out_d", o_data[3], pk[k]);
    end
    repeat (3) @(negedge clk);
    chk("bp_empty", pending(), 0);

    drop_one(0, 3);
    drop_one(3, 0);
    @(posedge clk); #1;
    b_valid[0] = 1; b_data[0] = {16'(seq), 12'd0, 2'd2, 2'd2};
    @(posedge clk); #1 b_valid[0] = 0;
    @(negedge clk); chk("b_lat1", b_ovalid, 0);
    @(negedge clk); chk("b_east_v", b_ovalid, 5'b01000); chk("b_east_d", b_odata[3], {16'(seq), 12'd0, 2'd2, 2'd2});
    chk("b_nodrop", b_drop, 0);

    mode = 1; en = 5'b10111; prev = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (c >= 4) begin
        s = int'(o_data[3][10:8]);
        chk("fair_v", o_valid[3], 1);
        if (c >= 5) chk("fair_rr", s, nxt(prev));
        prev = s;
      end
      step();
    end
    en = '0;
    repeat (30) begin @(negedge clk); step(); end
    chk("fair_drain", pending(), 0);

    mode = 2; en = 5'b10010;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (c >= 4) chk("par_v", {o_valid[2], o_valid[3]}, 2'b11);
      step();
    end
    en = '0;
    repeat (20) begin @(negedge clk); step(); end
    chk("par_drain", pending(), 0);

    mode = 0; en = '1; rnd_valid = 1; rnd_rdy = 1;
    repeat (800) begin @(negedge clk); step(); end
    mid_reset();
    i_ready = '1; rnd_rdy = 0;
    repeat (8) begin
      @(negedge clk);
      chk("post_rst_v", o_valid, 0);
      chk("post_rst_rdy", o_ready, 5'h1f);
      step();
    end
    en = '1; rnd_rdy = 1;
    repeat (1200) begin @(negedge clk); step(); end
    en = '0; rnd_rdy = 0; i_ready = '1;
    repeat (40) begin @(negedge clk); step(); end
    chk("rand_drain", pending(), 0);
    chk("rand_idle", o_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
